cda_meas_ctrl: RTL
==================

Name: cda_meas_ctrl

Overview:
Measurement sequencer for the CDA coincidence/delay-line block. On a start request it clears the CDA, enables it for a fixed capture window, waits for the encoder to settle, and samples the binary code. It repeats this 2^AVG_LOG2 times, accumulates the codes and presents sum, average and saturation flag on a valid/ready result port. It sits between the host/register interface and the CDA datapath, and owns the CDA's en and local clear.

Parameters:
CODE_W, 7, width of CDA encoder code (87 stages -> 7 bits)
WIN_CYC, 88, cycles cda_en is held high per sample (>= STAGES+1 to flush the delay line); must be >= 1
CLR_CYC, 2, cycles cda_rst is held high before each window; must be >= 1
SETTLE_CYC, 2, extra cycles cda_en stays high after the window before sampling; must be >= 1
AVG_LOG2, 2, log2 of samples per measurement (0 = single shot)
SAT_CODE, 87, code at or above which a sample counts as saturated

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  measurement request; accepted only in IDLE
abort  input  1  cancel any measurement in progress
busy  output  1  high in every state except IDLE
cda_rst  output  1  local clear to CDA datapath
cda_en  output  1  enable to CDA shift register/encoder
cda_code  input  CODE_W  binary code from CDA encoder
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_avg  output  CODE_W  res_sum >> AVG_LOG2, truncated
res_sum  output  CODE_W+AVG_LOG2  sum of all sampled codes
res_sat  output  1  any sample in this measurement >= SAT_CODE

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: state IDLE, busy 0, cda_en 0, cda_rst 1, res_valid 0, res_avg 0, res_sum 0, res_sat 0, all counters 0.
- FSM states: IDLE, CLEAR, WINDOW, SETTLE, DONE.
- IDLE: cda_rst=1, cda_en=0. start=1 -> CLEAR; accumulator, sat flag and sample counter zeroed on the same edge.
- CLEAR: cda_rst=1, cda_en=0, for CLR_CYC cycles -> WINDOW.
- WINDOW: cda_rst=0, cda_en=1, for WIN_CYC cycles -> SETTLE.
- SETTLE: cda_rst=0, cda_en=1, for SETTLE_CYC cycles. cda_code is sampled on the edge ending the last SETTLE cycle, on which:
  - acc += code (zero-extended);
  - sat |= (code >= SAT_CODE);
  - sample counter increments.
- After SETTLE: if 2^AVG_LOG2 samples are done -> DONE; otherwise -> CLEAR.
- DONE: cda_rst=1, cda_en=0. res_valid=1; res_sum, res_avg and res_sat are registered on entry and held stable. res_valid && res_ready -> IDLE next edge, res_valid drops.
- Latency: start sampled at edge E0 -> res_valid high from edge E0 + 2^AVG_LOG2*(CLR_CYC+WIN_CYC+SETTLE_CYC). Defaults: 4*92 = 368 cycles.
- start outside IDLE is ignored, not queued.
- abort (any state) -> IDLE on the next edge. res_valid=0, accumulator discarded, result registers keep their previous values. Abort and start together in IDLE: abort wins, no measurement starts.
- Reset mid-operation: same as abort, and result registers also clear.
- Width rules:
  - accumulator is CODE_W+AVG_LOG2 bits and cannot overflow;
  - phase counter is sized to clog2(max(CLR_CYC, WIN_CYC, SETTLE_CYC)+1);
  - sample counter is AVG_LOG2+1 bits.
- Outputs cda_en and cda_rst are registered and glitch-free; they are never both high.

Decomposition:
- Shared package/header cda_pkg: CODE_W, default timing constants (WIN_CYC, CLR_CYC, SETTLE_CYC), FSM state encoding.
- Sub-module cda_accum: clear, add-on-sample, sat OR, and shifted average output.
- FSM and phase/sample counters stay in cda_meas_ctrl.

Test Plan:
- Reset during WINDOW (rst high 3 cycles) -> next edge busy 0, cda_en 0, cda_rst 1, res_valid 0, res_sum 0; a following start runs a full measurement normally.
- AVG_LOG2=0, cda_code=37 constant, start at E0:
  - cda_rst high 2 cycles, then cda_en high exactly 90 cycles;
  - res_valid at E0+92 with res_sum=37, res_avg=37, res_sat=0.
- AVG_LOG2=2, code 10/11/12/14 in successive SETTLE phases -> res_sum=47, res_avg=11, res_sat=0, res_valid at E0+368.
- Backpressure: hold res_ready=0 for 20 cycles in DONE, pulsing start -> res_valid and outputs stable, start ignored; res_ready=1 -> IDLE next edge, busy 0.
- Abort during SETTLE of sample 3 -> IDLE next edge, res_valid never asserts. A following start with code=5 gives res_sum=20, with no residue from the aborted run.
- Saturation: one of 4 samples = 87, others 0 -> res_sat=1, res_sum=87, res_avg=21. Next measurement with all codes 3 -> res_sat=0.

Source files
------------

// File: rtl/cda_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the CDA measurement sequencer.
package cda_pkg;

    localparam int CDA_CODE_W     = 7;
    localparam int CDA_WIN_CYC    = 88;
    localparam int CDA_CLR_CYC    = 2;
    localparam int CDA_SETTLE_CYC = 2;
    localparam int CDA_AVG_LOG2   = 2;
    localparam int CDA_SAT_CODE   = 87;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WINDOW,
        ST_SETTLE,
        ST_DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cda_accum.sv
// Sample accumulator with sticky saturation flag and result registers loaded on measurement completion.
module cda_accum #(
    parameter int CODE_W   = cda_pkg::CDA_CODE_W,
    parameter int AVG_LOG2 = cda_pkg::CDA_AVG_LOG2,
    parameter int SAT_CODE = cda_pkg::CDA_SAT_CODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       sample,
    input  logic                       load,
    input  logic [CODE_W-1:0]          code,
    output logic [CODE_W+AVG_LOG2-1:0] res_sum,
    output logic [CODE_W-1:0]          res_avg,
    output logic                       res_sat
);

    localparam int ACC_W = CODE_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d, acc_add;
    logic             sat_q, sat_d, sat_add;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             rsat_q, rsat_d;

    // load coincides with the final sample, so the result takes the post-add value
    always_comb begin
        acc_add = acc_q + ACC_W'(code);
        sat_add = sat_q | (code >= CODE_W'(SAT_CODE));
        acc_d   = acc_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        rsat_d  = rsat_q;
        if (clear) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (sample) begin
            acc_d = acc_add;
            sat_d = sat_add;
        end
        if (load) begin
            sum_d  = acc_add;
            rsat_d = sat_add;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            sum_q  <= '0;
            rsat_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sat_q  <= sat_d;
            sum_q  <= sum_d;
            rsat_q <= rsat_d;
        end
    end

    assign res_sum = sum_q;
    assign res_avg = sum_q[ACC_W-1 -: CODE_W];
    assign res_sat = rsat_q;

endmodule

// File: rtl/cda_meas_ctrl.sv
// CDA measurement sequencer: clear/window/settle per sample, averaged over 2^AVG_LOG2 samples.
module cda_meas_ctrl
    import cda_pkg::*;
#(
    parameter int CODE_W     = CDA_CODE_W,
    parameter int WIN_CYC    = CDA_WIN_CYC,
    parameter int CLR_CYC    = CDA_CLR_CYC,
    parameter int SETTLE_CYC = CDA_SETTLE_CYC,
    parameter int AVG_LOG2   = CDA_AVG_LOG2,
    parameter int SAT_CODE   = CDA_SAT_CODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       cda_rst,
    output logic                       cda_en,
    input  logic [CODE_W-1:0]          cda_code,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CODE_W-1:0]          res_avg,
    output logic [CODE_W+AVG_LOG2-1:0] res_sum,
    output logic                       res_sat
);

    localparam int PH_W   = $clog2(max3(CLR_CYC, WIN_CYC, SETTLE_CYC) + 1);
    localparam int SAMP_W = AVG_LOG2 + 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << AVG_LOG2) - 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic              cda_en_q, cda_en_d;
    logic              cda_rst_q, cda_rst_d;
    logic              acc_clear, acc_sample, acc_load;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        samp_d     = samp_q;
        acc_clear  = 1'b0;
        acc_sample = 1'b0;
        acc_load   = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            ph_d      = '0;
            samp_d    = '0;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_CLEAR;
                        ph_d      = '0;
                        samp_d    = '0;
                        acc_clear = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (ph_q == PH_W'(CLR_CYC - 1)) begin
                        state_d = ST_WINDOW;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                ST_WINDOW: begin
                    if (ph_q == PH_W'(WIN_CYC - 1)) begin
                        state_d = ST_SETTLE;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                        acc_sample = 1'b1;
                        ph_d       = '0;
                        samp_d     = samp_q + 1'b1;
                        if (samp_q == SAMP_LAST) begin
                            state_d  = ST_DONE;
                            acc_load = 1'b1;
                        end else begin
                            state_d = ST_CLEAR;
                        end
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // enable/clear are decoded from the next state so the flops line up with the state register
        cda_en_d  = (state_d == ST_WINDOW) || (state_d == ST_SETTLE);
        cda_rst_d = !cda_en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            samp_q    <= '0;
            cda_en_q  <= 1'b0;
            cda_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            samp_q    <= samp_d;
            cda_en_q  <= cda_en_d;
            cda_rst_q <= cda_rst_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign cda_en    = cda_en_q;
    assign cda_rst   = cda_rst_q;

    cda_accum #(
        .CODE_W  (CODE_W),
        .AVG_LOG2(AVG_LOG2),
        .SAT_CODE(SAT_CODE)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .sample (acc_sample),
        .load   (acc_load),
        .code   (cda_code),
        .res_sum(res_sum),
        .res_avg(res_avg),
        .res_sat(res_sat)
    );

endmodule
